// File: rtl/down_counter_sched.sv
// down_counter_sched: round-robin owner of one shared
// load/decrement counter, one programmable delay per requester.
module down_counter_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_delay,
  input  logic [WIDTH-1:0]      cnt_dout,
  output logic                  cnt_ld,
  output logic [WIDTH-1:0]      cnt_ldvalue,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  g;
  logic [IW-1:0]  last;
  logic [IW-1:0]  pick;
  logic [IW-1:0]  cand;
  logic           found;
  logic [WIDTH-1:0] dly [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dly[i] = req_delay[i*WIDTH +: WIDTH];
    end
  end

  // First pending index after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      g           <= '0;
      last        <= IW'(NREQ - 1);
      cnt_ld      <= 1'b0;
      cnt_ldvalue <= '0;
      grant       <= '0;
      done        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= '0;
          if (found) begin
            state       <= LOAD;
            g           <= pick;
            last        <= pick;
            grant       <= ONE << pick;
            cnt_ld      <= 1'b1;
            cnt_ldvalue <= dly[pick];
          end else begin
            grant       <= '0;
            cnt_ld      <= 1'b0;
            cnt_ldvalue <= '0;
          end
        end
        LOAD: begin
          cnt_ld <= 1'b0;
          if (!req[g]) begin
            state       <= IDLE;
            grant       <= '0;
            cnt_ldvalue <= '0;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          // A dropped request wins over a simultaneous expiry.
          if (!req[g]) begin
            state       <= IDLE;
            grant       <= '0;
            cnt_ldvalue <= '0;
          end else if (cnt_dout == '0) begin
            state <= DONE;
            done  <= ONE << g;
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= '0;
          grant       <= '0;
          cnt_ldvalue <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
